// File: rtl/mw_pkg.sv
// Shared types and default sizing for the microwave timer controller.
package mw_pkg;

  localparam int unsigned TimeWDef     = 8;
  localparam int unsigned PwrWDef      = 3;
  localparam int unsigned BellTicksDef = 3;

  typedef enum logic [4:0] {
    StClosed = 5'b00001,
    StCook   = 5'b00010,
    StPause  = 5'b00100,
    StBell   = 5'b01000,
    StOpen   = 5'b10000
  } mw_state_e;

endpackage

// File: rtl/mw_duty_gen.sv
// Tick-driven duty counter; duty_on is high while the count is below the power level.
module mw_duty_gen #(
  parameter int unsigned PWR_W = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             advance,
  input  logic [PWR_W-1:0] power_q,
  output logic             duty_on
);

  // Period is 2**PWR_W-1 ticks so that full power gives continuous heat.
  localparam logic [PWR_W-1:0] DutyMax = PWR_W'((1 << PWR_W) - 2);

  logic [PWR_W-1:0] duty_cnt_q, duty_cnt_d;

  always_comb begin
    duty_cnt_d = duty_cnt_q;
    if (clear) begin
      duty_cnt_d = '0;
    end else if (advance) begin
      duty_cnt_d = (duty_cnt_q == DutyMax) ? '0 : duty_cnt_q + PWR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      duty_cnt_q <= '0;
    end else begin
      duty_cnt_q <= duty_cnt_d;
    end
  end

  assign duty_on = (duty_cnt_q < power_q);

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave cook-timer controller: countdown, power duty cycle, bell and done strobe.
// Optional child lock enabled by defining MW_CHILD_LOCK_EN.
module microwave_timer_ctrl
  import mw_pkg::*;
#(
  parameter int unsigned TIME_W     = TimeWDef,
  parameter int unsigned PWR_W      = PwrWDef,
  parameter int unsigned BELL_TICKS = BellTicksDef
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              tick,
  input  logic              start,
  input  logic              cancel,
  input  logic              door,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PWR_W-1:0]  power,
`ifdef MW_CHILD_LOCK_EN
  input  logic              lock,
  output logic              locked,
`endif
  output logic              heat,
  output logic              light,
  output logic              bell,
  output logic              done,
  output logic [TIME_W-1:0] remaining
);

  localparam int unsigned BellW = (BELL_TICKS > 1) ? $clog2(BELL_TICKS) : 1;
  localparam logic [BellW-1:0] BellLast = BellW'(BELL_TICKS - 1);

  mw_state_e         state_q, state_d;
  logic [TIME_W-1:0] remaining_q, remaining_d;
  logic [PWR_W-1:0]  power_q, power_d;
  logic [BellW-1:0]  bell_cnt_q, bell_cnt_d;
  logic              done_q, done_d;
  logic              duty_clear, duty_advance, duty_on;
  logic              start_ok;
  logic              pause_has_time;

`ifdef MW_CHILD_LOCK_EN
  logic locked_q;
  always_ff @(posedge clk) begin
    if (!nrst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= lock;
    end
  end
  assign locked   = locked_q;
  assign start_ok = start && !locked_q && (time_in != '0) && (power != '0);
`else
  assign start_ok = start && (time_in != '0) && (power != '0);
`endif

  // A cancel in PAUSE clears the time, so closing the door in that same cycle ends the cook.
  assign pause_has_time = !cancel && (remaining_q != '0);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= StClosed;
      remaining_q <= '0;
      power_q     <= '0;
      bell_cnt_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      power_q     <= power_d;
      bell_cnt_q  <= bell_cnt_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    power_d      = power_q;
    bell_cnt_d   = bell_cnt_q;
    done_d       = 1'b0;
    duty_clear   = 1'b0;
    duty_advance = 1'b0;
    unique case (state_q)
      StClosed: begin
        if (door) begin
          state_d = StOpen;
        end else if (start_ok) begin
          state_d     = StCook;
          remaining_d = time_in;
          power_d     = power;
          duty_clear  = 1'b1;
        end
      end
      StCook: begin
        duty_advance = tick;
        if (door) begin
          state_d = StPause;
        end else if (cancel) begin
          state_d     = StClosed;
          remaining_d = '0;
        end else if (tick) begin
          if (remaining_q == TIME_W'(1)) begin
            state_d     = StBell;
            remaining_d = '0;
            done_d      = 1'b1;
            bell_cnt_d  = '0;
          end else begin
            remaining_d = remaining_q - TIME_W'(1);
          end
        end
      end
      StPause: begin
        if (cancel) begin
          remaining_d = '0;
        end
        if (!door) begin
          if (pause_has_time) begin
            state_d    = StCook;
            duty_clear = 1'b1;
          end else begin
            state_d = StClosed;
          end
        end
      end
      StBell: begin
        if (door) begin
          state_d = StOpen;
        end else if (cancel) begin
          state_d = StClosed;
        end else if (tick) begin
          if (bell_cnt_q == BellLast) begin
            state_d = StClosed;
          end else begin
            bell_cnt_d = bell_cnt_q + BellW'(1);
          end
        end
      end
      StOpen: begin
        if (!door) begin
          state_d = StClosed;
        end
      end
      default: begin
        state_d     = StClosed;
        remaining_d = '0;
      end
    endcase
  end

  mw_duty_gen #(
    .PWR_W(PWR_W)
  ) u_duty_gen (
    .clk    (clk),
    .nrst   (nrst),
    .clear  (duty_clear),
    .advance(duty_advance),
    .power_q(power_q),
    .duty_on(duty_on)
  );

  // Heat looks at the live door input so opening the door cuts the magnetron immediately.
  always_comb begin
    heat  = (state_q == StCook) && !door && duty_on;
    light = (state_q == StCook) || (state_q == StPause) || (state_q == StOpen);
    bell  = (state_q == StBell);
  end

  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Directed self-checking bench for microwave_timer_ctrl with default sizing.
module tb_microwave_timer_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic       tick, start, cancel, door;
  logic [7:0] time_in;
  logic [2:0] power;
  logic       heat, light, bell, done;
  logic [7:0] remaining;
`ifdef MW_CHILD_LOCK_EN
  logic       lock;
  logic       locked;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  microwave_timer_ctrl dut (
    .clk      (clk),
    .nrst     (nrst),
    .tick     (tick),
    .start    (start),
    .cancel   (cancel),
    .door     (door),
    .time_in  (time_in),
    .power    (power),
`ifdef MW_CHILD_LOCK_EN
    .lock     (lock),
    .locked   (locked),
`endif
    .heat     (heat),
    .light    (light),
    .bell     (bell),
    .done     (done),
    .remaining(remaining)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] t, input logic [2:0] p);
    time_in = t;
    power   = p;
    start   = 1'b1;
    step(1);
    start   = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; tick = 1'b0; start = 1'b0; cancel = 1'b0; door = 1'b0;
    time_in = '0; power = '0;
`ifdef MW_CHILD_LOCK_EN
    lock = 1'b0;
`endif
    step(2);
    check_eq("rst_remaining", remaining, 0);
    check_eq("rst_heat", heat, 0);
    check_eq("rst_light", light, 0);
    check_eq("rst_bell", bell, 0);
    check_eq("rst_done", done, 0);
    nrst = 1'b1;
    step(1);

    // Basic countdown, bell and auto-return.
    do_start(8'd3, 3'd7);
    check_eq("cook_light", light, 1);
    check_eq("cook_heat", heat, 1);
    check_eq("cook_rem3", remaining, 3);
    do_tick();
    check_eq("cook_rem2", remaining, 2);
    do_tick();
    check_eq("cook_rem1", remaining, 1);
    check_eq("cook_done_early", done, 0);
    do_tick();
    check_eq("bell_on", bell, 1);
    check_eq("bell_done", done, 1);
    check_eq("bell_rem0", remaining, 0);
    check_eq("bell_light", light, 0);
    step(1);
    check_eq("done_one_cycle", done, 0);
    do_tick();
    do_tick();
    check_eq("bell_still", bell, 1);
    do_tick();
    check_eq("bell_off", bell, 0);
    check_eq("closed_light", light, 0);

    // Power 2 duty pattern: on for duty 0,1 of a 7-tick period.
    do_start(8'd14, 3'd2);
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("duty_%0d", i), heat, ((i % 7) < 2) ? 1 : 0);
      do_tick();
    end
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    check_eq("duty_cancel_rem", remaining, 0);

    // Door pause with simultaneous tick, then resume.
    do_start(8'd5, 3'd7);
    check_eq("pause_pre_heat", heat, 1);
    door = 1'b1;
    #1;
    check_eq("door_cuts_heat", heat, 0);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check_eq("pause_rem_door_tick", remaining, 5);
    check_eq("pause_light", light, 1);
    for (int i = 0; i < 4; i++) do_tick();
    check_eq("pause_rem_hold", remaining, 5);
    check_eq("pause_heat", heat, 0);
    door = 1'b0;
    step(1);
    check_eq("resume_heat", heat, 1);
    do_tick();
    check_eq("resume_rem4", remaining, 4);

    // Cancel in COOK at remaining 4.
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    check_eq("cancel_rem", remaining, 0);
    check_eq("cancel_light", light, 0);
    check_eq("cancel_done", done, 0);

    // Cancel in PAUSE, then close door.
    do_start(8'd5, 3'd7);
    door = 1'b1;
    step(1);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    check_eq("pcancel_rem", remaining, 0);
    check_eq("pcancel_light", light, 1);
    door = 1'b0;
    step(1);
    check_eq("pcancel_closed_light", light, 0);

    // Tick and cancel together at remaining 1: no done.
    do_start(8'd1, 3'd7);
    tick = 1'b1;
    cancel = 1'b1;
    step(1);
    tick = 1'b0;
    cancel = 1'b0;
    check_eq("tickcancel_done", done, 0);
    check_eq("tickcancel_bell", bell, 0);
    check_eq("tickcancel_light", light, 0);

    // Zero time or zero power start is ignored.
    do_start(8'd0, 3'd5);
    check_eq("zero_time_light", light, 0);
    check_eq("zero_time_heat", heat, 0);
    do_start(8'd5, 3'd0);
    check_eq("zero_pwr_light", light, 0);
    check_eq("zero_pwr_rem", remaining, 0);

    // Door in BELL goes to OPEN.
    do_start(8'd1, 3'd7);
    do_tick();
    check_eq("bell2_on", bell, 1);
    door = 1'b1;
    step(1);
    check_eq("open_bell", bell, 0);
    check_eq("open_light", light, 1);
    door = 1'b0;
    step(1);
    check_eq("open_closed_light", light, 0);

    // All-ones time, then reset mid-cook.
    do_start(8'hff, 3'd7);
    check_eq("max_rem", remaining, 255);
    do_tick();
    check_eq("max_rem_dec", remaining, 254);
    nrst = 1'b0;
    step(1);
    check_eq("midrst_rem", remaining, 0);
    check_eq("midrst_light", light, 0);
    check_eq("midrst_heat", heat, 0);
    check_eq("midrst_bell", bell, 0);
    check_eq("midrst_done", done, 0);
    nrst = 1'b1;
    step(1);

`ifdef MW_CHILD_LOCK_EN
    lock = 1'b1;
    step(1);
    check_eq("locked_out", locked, 1);
    do_start(8'd5, 3'd7);
    check_eq("lock_ignored", light, 0);
    lock = 1'b0;
    step(1);
    do_start(8'd5, 3'd7);
    check_eq("unlock_cook", light, 1);
    check_eq("unlock_rem", remaining, 5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
